double_stream_reader: RTL and testbench

- Sequencer that streams IEEE-754 doubles out of a byte-wide sample memory.
- A command gives a byte offset and a count of doubles.
- For each double, the block issues 8 consecutive byte reads and assembles the bytes little-endian, byte 0 at bits [7:0].
- Each assembled 64-bit word is presented on a valid/ready stream to the floating-point datapath under test. The block is the hardware counterpart of the bench's file-based double loader.

---
 rtl/double_stream_reader_pkg.sv | 23 ++
 rtl/double_stream_reader_if.sv | 44 ++++
 rtl/double_stream_reader_byte_assembler.sv | 48 ++++
 rtl/double_stream_reader.sv | 180 ++++++++++++++++++
 tb/tb_double_stream_reader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/double_stream_reader_pkg.sv
// Shared types for the double stream reader: FSM state encoding, the 64-bit
// double container and the byte-lane placement helper.
package dsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    DRAIN   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } dsr_state_t;

  localparam int BYTES_PER_DOUBLE = 8;

  typedef logic [63:0] double_bits_t;

  // Byte lane that byte k of a double lands in: k for little-endian,
  // 7-k for big-endian.
  function automatic logic [2:0] byte_lane(input logic [2:0] idx, input logic big_endian);
    return big_endian ? (3'd7 - idx) : idx;
  endfunction

endpackage

// File: rtl/double_stream_reader_if.sv
// Command, memory and output stream bundle of the double stream reader.
// DOUBLE_STREAM_READER_BIG_ENDIAN_EN adds the cmd_big_endian command field.
interface double_stream_reader_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_offset;
  logic [LEN_W-1:0]  cmd_length;
`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
  logic              cmd_big_endian;
`endif
  logic              abort;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  // Environment side: issues commands, models the memory, consumes doubles.
  modport master (
    output cmd_valid, cmd_offset, cmd_length,
`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
    output cmd_big_endian,
`endif
    output abort, mem_rdata, out_ready,
    input  cmd_ready, mem_rd_en, mem_addr, out_valid, out_data, out_last, busy, done
  );

  // Reader side.
  modport slave (
    input  cmd_valid, cmd_offset, cmd_length,
`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
    input  cmd_big_endian,
`endif
    input  abort, mem_rdata, out_ready,
    output cmd_ready, mem_rd_en, mem_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/double_stream_reader_byte_assembler.sv
// dsr_byte_assembler: places returned memory bytes into a 64-bit word.
// With DOUBLE_STREAM_READER_BIG_ENDIAN_EN the big_endian input mirrors lanes.
module dsr_byte_assembler
  import dsr_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         cap_en,
  input  logic [2:0]   cap_idx,
  input  logic [7:0]   rdata,
`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
  input  logic         big_endian,
`endif
  output double_bits_t data
);

  logic         big_endian_s;
  logic [2:0]   lane_s;
  double_bits_t data_r;

`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
  assign big_endian_s = big_endian;
`else
  assign big_endian_s = 1'b0;
`endif

  // Select the destination byte lane for the byte being captured.
  always_comb begin
    lane_s = byte_lane(cap_idx, big_endian_s);
  end

  // Word register: cleared on reset and at command start, one lane written per capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (clear) begin
      data_r <= '0;
    end else if (cap_en) begin
      data_r[{lane_s, 3'b000} +: 8] <= rdata;
    end else begin
      data_r <= data_r;
    end
  end

  assign data = data_r;

endmodule

// File: rtl/double_stream_reader.sv
// double_stream_reader: streams doubles out of a byte-wide sample memory,
// eight byte reads per double, then one output beat per double.
// DOUBLE_STREAM_READER_BIG_ENDIAN_EN enables per-command big-endian assembly.
module double_stream_reader
  import dsr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
)(
  input logic                  clk,
  input logic                  rst_n,
  double_stream_reader_if.slave bus
);

  dsr_state_t        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  remaining_r;
  logic [2:0]        byte_idx_r;
  logic              mem_rd_en_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic              busy_r;
  logic              done_r;
  logic              cmd_ready_r;
  logic              cap_en_r;
  logic [2:0]        cap_idx_r;
  logic              cmd_take_s;
  double_bits_t      asm_data_s;
`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
  logic              big_endian_r;
`endif

  // abort in IDLE vetoes acceptance in the same cycle
  assign cmd_take_s = (state_r == IDLE) && bus.cmd_valid && !bus.abort;

  // Main sequencer: command acceptance, byte reads, presentation and completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      remaining_r <= '0;
      byte_idx_r  <= 3'd0;
      mem_rd_en_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else if (bus.abort && (state_r != IDLE)) begin
      state_r     <= IDLE;
      mem_rd_en_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (cmd_take_s) begin
            addr_r      <= bus.cmd_offset;
            remaining_r <= bus.cmd_length;
            byte_idx_r  <= 3'd0;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            if (bus.cmd_length == LEN_W'(0)) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= READ;
              mem_rd_en_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          addr_r     <= addr_r + ADDR_W'(1);
          byte_idx_r <= byte_idx_r + 3'd1;
          if (byte_idx_r == 3'(BYTES_PER_DOUBLE - 1)) begin
            state_r     <= DRAIN;
            mem_rd_en_r <= 1'b0;
          end else begin
            state_r <= READ;
          end
        end
        DRAIN: begin
          // last byte lands in the assembler on this same edge
          state_r     <= PRESENT;
          out_valid_r <= 1'b1;
          out_last_r  <= (remaining_r == LEN_W'(1));
        end
        PRESENT: begin
          if (bus.out_ready) begin
            remaining_r <= remaining_r - LEN_W'(1);
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (remaining_r == LEN_W'(1)) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= READ;
              byte_idx_r  <= 3'd0;
              mem_rd_en_r <= 1'b1;
            end
          end else begin
            state_r <= PRESENT;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          mem_rd_en_r <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
  // Byte order is fixed for the whole command at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      big_endian_r <= 1'b0;
    end else if (cmd_take_s) begin
      big_endian_r <= bus.cmd_big_endian;
    end else begin
      big_endian_r <= big_endian_r;
    end
  end
`endif

  // Delay the read strobe and byte index to line up with returning memory data;
  // abort and reset squash an in-flight byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_en_r  <= 1'b0;
      cap_idx_r <= 3'd0;
    end else if (bus.abort && (state_r != IDLE)) begin
      cap_en_r  <= 1'b0;
      cap_idx_r <= 3'd0;
    end else begin
      cap_en_r  <= mem_rd_en_r;
      cap_idx_r <= byte_idx_r;
    end
  end

  dsr_byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cmd_take_s),
    .cap_en     (cap_en_r),
    .cap_idx    (cap_idx_r),
    .rdata      (bus.mem_rdata),
`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
    .big_endian (big_endian_r),
`endif
    .data       (asm_data_s)
  );

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.mem_rd_en = mem_rd_en_r;
  assign bus.mem_addr  = addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_data  = asm_data_s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_double_stream_reader.sv
// Scoreboard bench for double_stream_reader: expected addresses and doubles are
// queued when a command is issued, monitors pop and compare on each read strobe
// and output handshake. Covers the big-endian build when
// DOUBLE_STREAM_READER_BIG_ENDIAN_EN is defined.
module tb_double_stream_reader;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   rd_cnt = 0;
  int   hs_cnt = 0;

  logic [7:0]  mem [0:65535];
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  exp_t        mon_e;
  logic [15:0] mon_a;

  double_stream_reader_if #(.ADDR_W(16), .LEN_W(16)) bus ();

  double_stream_reader #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: data returned one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: address scoreboard, output scoreboard, stall stability, done count.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.mem_rd_en === 1'b1) begin
        rd_cnt++;
        if (addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: got read at %h, required no read", bus.mem_addr);
        end else begin
          mon_a = addr_q.pop_front();
          check("mem_addr", {48'd0, bus.mem_addr}, {48'd0, mon_a});
        end
      end
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: got out_valid with data %h, required none", bus.out_data);
        end else if (bus.out_ready === 1'b1) begin
          mon_e = exp_q.pop_front();
          hs_cnt++;
          check("out_data", bus.out_data, mon_e.data);
          check("out_last", {63'd0, bus.out_last}, {63'd0, mon_e.last});
        end else begin
          check("stall_data", bus.out_data, exp_q[0].data);
          check("stall_last", {63'd0, bus.out_last}, {63'd0, exp_q[0].last});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_addrs(input logic [15:0] off, input int nbytes);
    for (int i = 0; i < nbytes; i++) addr_q.push_back(off + 16'(i));
  endtask

  task automatic send_cmd(input logic [15:0] off, input logic [15:0] len);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_idle", {63'd0, bus.cmd_ready}, 64'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_offset = off;
    bus.cmd_length = len;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  // From the cycle after a command/handshake edge, the next out_valid is 9 cycles away.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s: out_valid timeout after %0d cycles, required within 40", name, n);
    end else begin
      check(name, 64'(n), 64'd9);
    end
  endtask

  // Handshake cycle is current; done must be high the following cycle only.
  task automatic finish_single(input string name);
    tick();
    check({name, "_done"}, {63'd0, bus.done}, 64'd1);
    tick();
    check({name, "_done_drop"}, {63'd0, bus.done}, 64'd0);
    check({name, "_ready_back"}, {63'd0, bus.cmd_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    int h0;
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_offset = 16'h0000;
    bus.cmd_length = 16'h0000;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b1;
`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
    bus.cmd_big_endian = 1'b0;
`endif
    for (int i = 0; i < 8; i++) mem[16'h0100 + 16'(i)] = 8'h00;
    mem[16'h0106] = 8'hF0;
    mem[16'h0107] = 8'h3F;
    for (int i = 0; i < 24; i++) mem[16'h0200 + 16'(i)] = 8'h10 + 8'(i);
    for (int i = 0; i < 8; i++) mem[16'h0300 + 16'(i)] = 8'hA0 + 8'(i);
    mem[16'hFFFC] = 8'h11; mem[16'hFFFD] = 8'h22; mem[16'hFFFE] = 8'h33; mem[16'hFFFF] = 8'h44;
    mem[16'h0000] = 8'h55; mem[16'h0001] = 8'h66; mem[16'h0002] = 8'h77; mem[16'h0003] = 8'h88;
    for (int i = 0; i < 8; i++) mem[16'h0400 + 16'(i)] = 8'h00;
    mem[16'h0400] = 8'h3F;
    mem[16'h0401] = 8'hF0;

    // Reset state
    tick(); tick();
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy",      {63'd0, bus.busy},      64'd0);
    check("rst_done",      {63'd0, bus.done},      64'd0);
    check("rst_rd_en",     {63'd0, bus.mem_rd_en}, 64'd0);
    check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check("rst_out_data",  bus.out_data,           64'd0);
    rst_n = 1'b1;
    tick();

    // Little-endian 1.0
    push_addrs(16'h0100, 8);
    exp_q.push_back('{data: 64'h3FF0_0000_0000_0000, last: 1'b1});
    send_cmd(16'h0100, 16'd1);
    check("t1_busy", {63'd0, bus.busy}, 64'd1);
    wait_valid("t1_latency");
    finish_single("t1");

    // Three doubles, 2nd stalled
    d0 = done_cnt;
    h0 = hs_cnt;
    push_addrs(16'h0200, 24);
    exp_q.push_back('{data: 64'h1716_1514_1312_1110, last: 1'b0});
    exp_q.push_back('{data: 64'h1F1E_1D1C_1B1A_1918, last: 1'b0});
    exp_q.push_back('{data: 64'h2726_2524_2322_2120, last: 1'b1});
    send_cmd(16'h0200, 16'd3);
    wait_valid("t2_latency1");
    tick();
    bus.out_ready = 1'b0;
    wait_valid("t2_latency2");
    repeat (5) tick();
    check("t2_stall_valid", {63'd0, bus.out_valid}, 64'd1);
    bus.out_ready = 1'b1;
    tick();
    wait_valid("t2_latency3");
    finish_single("t2");
    check("t2_handshakes", 64'(hs_cnt - h0), 64'd3);
    check("t2_done_count", 64'(done_cnt - d0), 64'd1);
    check("t2_remaining", {48'd0, dut.remaining_r}, 64'd0);

    // Zero length: done the cycle after acceptance, no reads, no output
    r0 = rd_cnt;
    h0 = hs_cnt;
    send_cmd(16'h0500, 16'd0);
    check("t3_done", {63'd0, bus.done}, 64'd1);
    check("t3_ready_low", {63'd0, bus.cmd_ready}, 64'd0);
    tick();
    check("t3_done_drop", {63'd0, bus.done}, 64'd0);
    check("t3_ready_back", {63'd0, bus.cmd_ready}, 64'd1);
    check("t3_no_reads", 64'(rd_cnt - r0), 64'd0);
    check("t3_no_output", 64'(hs_cnt - h0), 64'd0);

    // Address wrap
    push_addrs(16'hFFFC, 8);
    exp_q.push_back('{data: 64'h8877_6655_4433_2211, last: 1'b1});
    send_cmd(16'hFFFC, 16'd1);
    wait_valid("t4_latency");
    finish_single("t4");

    // abort in IDLE blocks acceptance
    bus.abort     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_offset = 16'h0300;
    bus.cmd_length = 16'd1;
    tick();
    bus.abort     = 1'b0;
    bus.cmd_valid = 1'b0;
    check("t5_idle_abort_busy", {63'd0, bus.busy}, 64'd0);
    check("t5_idle_abort_ready", {63'd0, bus.cmd_ready}, 64'd1);

    // abort at byte_idx 4, then a clean command
    d0 = done_cnt;
    push_addrs(16'h0300, 5);
    send_cmd(16'h0300, 16'd2);
    repeat (4) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_abort_busy",  {63'd0, bus.busy},      64'd0);
    check("t5_abort_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
    check("t5_abort_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t5_abort_ready", {63'd0, bus.cmd_ready}, 64'd1);
    repeat (3) tick();
    check("t5_abort_no_done", 64'(done_cnt - d0), 64'd0);
    push_addrs(16'h0100, 8);
    exp_q.push_back('{data: 64'h3FF0_0000_0000_0000, last: 1'b1});
    send_cmd(16'h0100, 16'd1);
    wait_valid("t5_latency");
    finish_single("t5");

    // Reset during PRESENT
    push_addrs(16'h0200, 8);
    exp_q.push_back('{data: 64'h1716_1514_1312_1110, last: 1'b1});
    bus.out_ready = 1'b0;
    send_cmd(16'h0200, 16'd1);
    wait_valid("t6_latency");
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t6_rst_busy",  {63'd0, bus.busy},      64'd0);
    check("t6_rst_data",  bus.out_data,           64'd0);
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    bus.out_ready = 1'b1;
    tick();

`ifdef DOUBLE_STREAM_READER_BIG_ENDIAN_EN
    // Big-endian 1.0
    push_addrs(16'h0400, 8);
    exp_q.push_back('{data: 64'h3FF0_0000_0000_0000, last: 1'b1});
    bus.cmd_big_endian = 1'b1;
    send_cmd(16'h0400, 16'd1);
    bus.cmd_big_endian = 1'b0;
    wait_valid("t7_latency");
    finish_single("t7");
`endif

    repeat (3) tick();
    check("exp_q_empty",  64'(exp_q.size()),  64'd0);
    check("addr_q_empty", 64'(addr_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
